// File: rtl/ddr2_sys_arb_pkg.sv
// Shared types and constants for the ddr2_sys on-chip RAM arbiter.
package ddr2_sys_arb_pkg;

    localparam int unsigned DEPTH     = 38400;
    localparam int unsigned MAX_BURST = 16;

    typedef enum logic [1:0] {
        IDLE,
        WR_BURST,
        RD_BURST
    } arb_state_e;

    // One entry per issued RAM read, tracked until its data is returned.
    typedef struct packed {
        logic valid;
        logic id;
        logic oor;
    } rd_entry_t;

endpackage

// File: rtl/ddr2_sys_arb_rdpipe.sv
// Read return pipeline: follows each issued read through the one-cycle RAM
// latency plus one output register, then steers the beat to its master.
module ddr2_sys_arb_rdpipe
    import ddr2_sys_arb_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  rd_entry_t         issue,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid
);

    rd_entry_t         s0_q;
    rd_entry_t         s1_q;
    logic [DATA_W-1:0] data_q;

    // Shift the read tags; capture RAM data when its tag reaches stage 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s0_q   <= '0;
            s1_q   <= '0;
            data_q <= '0;
        end else begin
            s0_q <= issue;
            s1_q <= s0_q;
            if (s0_q.valid) begin
                data_q <= mem_readdata;
            end
        end
    end

    // Demux to the owning master; out-of-range beats return zero.
    always_comb begin
        m0_readdatavalid = s1_q.valid && !s1_q.id;
        m1_readdatavalid = s1_q.valid && s1_q.id;
        m0_readdata      = (m0_readdatavalid && !s1_q.oor) ? data_q : '0;
        m1_readdata      = (m1_readdatavalid && !s1_q.oor) ? data_q : '0;
    end

endmodule

// File: rtl/ddr2_sys_onchip_mem_arbiter.sv
// Round-robin two-master burst arbiter in front of the ddr2_sys on-chip RAM.
// A grant is held for a whole burst; one RAM access per cycle at most.
module ddr2_sys_onchip_mem_arbiter #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = ddr2_sys_arb_pkg::DEPTH,
    parameter int unsigned BC_W   = 5
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [BC_W-1:0]     m0_burstcount,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [BC_W-1:0]     m1_burstcount,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    input  logic [DATA_W-1:0]   mem_readdata,
    output logic                mem_clken
);

    import ddr2_sys_arb_pkg::*;

    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(DEPTH);
    localparam logic [BC_W-1:0]   BC_ONE     = BC_W'(1);
    localparam logic [BC_W-1:0]   BC_MAX     = BC_W'(MAX_BURST);

    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BC_W-1:0]   cnt_q, cnt_d;
    logic              gnt_q, gnt_d;
    logic              last_grant_q, last_grant_d;
    logic              first_q, first_d;
    logic              clken_q;

    logic              m0_req, m1_req;
    logic              pick, pick_read;
    logic [BC_W-1:0]   pick_bc;
    logic              in_range;
    logic              sel_write;
    logic              grant_open;
    logic [ADDR_W-1:0] addr_next;
    rd_entry_t         issue;

    // Zero means a single beat; anything above the RAM's burst limit is clamped.
    function automatic logic [BC_W-1:0] burst_len(input logic [BC_W-1:0] bc);
        if (bc == '0) begin
            return BC_ONE;
        end
        if (bc > BC_MAX) begin
            return BC_MAX;
        end
        return bc;
    endfunction

    // State, burst address/count and arbitration history.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            cnt_q        <= '0;
            gnt_q        <= 1'b0;
            last_grant_q <= 1'b1;
            first_q      <= 1'b0;
            clken_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            gnt_q        <= gnt_d;
            last_grant_q <= last_grant_d;
            first_q      <= first_d;
            clken_q      <= 1'b1;
        end
    end

    // Arbitration, burst sequencing and RAM command generation.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        gnt_d        = gnt_q;
        last_grant_d = last_grant_q;
        first_d      = 1'b0;
        grant_open   = 1'b0;
        issue        = '0;

        m0_req    = m0_read | m0_write;
        m1_req    = m1_read | m1_write;
        pick      = (m0_req && m1_req) ? ~last_grant_q : m1_req;
        pick_read = pick ? m1_read : m0_read;
        pick_bc   = pick ? m1_burstcount : m0_burstcount;
        sel_write = gnt_q ? m1_write : m0_write;
        in_range  = addr_q < ADDR_LIMIT;
        // Saturate rather than wrap back into valid memory.
        addr_next = (addr_q == '1) ? addr_q : addr_q + ADDR_W'(1);

        mem_address    = addr_q;
        mem_byteenable = gnt_q ? m1_byteenable : m0_byteenable;
        mem_writedata  = gnt_q ? m1_writedata : m0_writedata;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;

        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    gnt_d        = pick;
                    last_grant_d = pick;
                    addr_d       = pick ? m1_address : m0_address;
                    cnt_d        = burst_len(pick_bc);
                    first_d      = pick_read;
                    state_d      = pick_read ? RD_BURST : WR_BURST;
                end
            end
            WR_BURST: begin
                grant_open = 1'b1;
                if (sel_write) begin
                    mem_chipselect = in_range;
                    mem_write      = in_range;
                    addr_d         = addr_next;
                    cnt_d          = cnt_q - BC_ONE;
                    if (cnt_q == BC_ONE) begin
                        state_d = IDLE;
                    end
                end
            end
            RD_BURST: begin
                // Only the command cycle is acknowledged; the rest is self-timed.
                grant_open     = first_q;
                mem_chipselect = in_range;
                mem_byteenable = '1;
                issue.valid    = 1'b1;
                issue.id       = gnt_q;
                issue.oor      = !in_range;
                addr_d         = addr_next;
                cnt_d          = cnt_q - BC_ONE;
                if (cnt_q == BC_ONE) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        m0_waitrequest = !(grant_open && !gnt_q);
        m1_waitrequest = !(grant_open && gnt_q);
    end

    assign mem_clken = clken_q;

    ddr2_sys_arb_rdpipe #(
        .DATA_W(DATA_W)
    ) u_rdpipe (
        .clk              (clk),
        .reset_n          (reset_n),
        .issue            (issue),
        .mem_readdata     (mem_readdata),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid)
    );

endmodule
